wb_seq_ctrl: RTL and testbench
==============================

Name: wb_seq_ctrl

Overview:
Sequencer for the MNIST MLP weight/bias memory (wbmem).
- On a start pulse, sweeps the layer-1 address counter ctr1 over all [W1|b1] words, then the layer-2 counter ctr2 over all [W2|b2] words, driving wbmem's re.
- Emits aligned valid/index/last tags for the MAC array, which consumes the wbmem outputs one cycle after each read.
- Honours a stall from the datapath and reports busy/done to the picoRV32-side glue.

Parameters:
L1_LEN, 785, words per layer-1 sweep (784 pixel weights + 1 bias); legal 1..1024
L2_LEN, 33, words per layer-2 sweep (32 hidden weights + 1 bias); legal 1..1024
GAP, 2, idle cycles between the layers for the layer-1 activation pipeline; legal 0..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run one inference; sampled only in IDLE
stall  in  1  datapath back-pressure; suppresses reads in L1/L2
ctr1  out  32  wbmem layer-1 address
ctr2  out  32  wbmem layer-2 address
re  out  1  wbmem read enable
wvalid  out  1  wbmem outputs hold a freshly read word this cycle
w_layer  out  1  layer of the word under wvalid: 0 = layer 1, 1 = layer 2
w_idx  out  32  address of the word under wvalid
w_last  out  1  with wvalid, marks the final word (bias) of the layer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE; ctr1 = 0, ctr2 = 0; re, wvalid, w_layer, w_last, busy, done = 0; w_idx = 0.
- States: IDLE, L1, GAP1, L2, DONE.
- re (combinational) = (state is L1 or L2) and !stall.
- ctr1/ctr2 are registered. They increment only on cycles with re = 1, and only the active layer's counter moves. The inactive counter holds 0.
- IDLE:
  - start = 1 takes the FSM to L1 next cycle.
  - start is ignored in all other states, including DONE.
- L1:
  - When re = 1 and ctr1 == L1_LEN-1: ctr1 returns to 0 and the FSM goes to GAP1 (or straight to L2 if GAP = 0).
  - stall = 1 holds ctr1 and the state indefinitely.
- GAP1: a GAP-cycle down-counter runs, then the FSM goes to L2. stall has no effect in GAP1.
- L2: same as L1 using ctr2 and L2_LEN. The last issue goes to DONE.
- DONE: one cycle with done = 1, then IDLE.
- busy = 1 in L1, GAP1, L2 and DONE.
- Read latency is 1 cycle, so all tags are registered copies of the issuing cycle:
  - wvalid(t+1) = re(t)
  - w_idx(t+1) = active address at t
  - w_layer(t+1) = (state == L2) at t
  - w_last(t+1) = re(t) and address == LEN-1
- The last layer-2 word is valid in the DONE cycle, so wvalid = w_last = done = 1 together.
- Stall on the final word: no issue happens, so no transition; the FSM waits.
- Reset mid-run: next cycle the block is in IDLE with all outputs at reset values. An in-flight wvalid is dropped.
- Counter width: addresses never exceed 1023. Upper bits [31:10] of ctr1/ctr2 are always 0.

Optional Feature:
WB_SEQ_PERF_EN defined:
- Adds outputs run_cycles[31:0] and stall_cycles[31:0].
- Both clear on start acceptance.
- run_cycles counts busy cycles; stall_cycles counts cycles in L1/L2 with stall = 1.
- Both saturate at 0xFFFFFFFF, hold after DONE until the next start, and clear on reset.

Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
1. Defaults, start at cycle 0, no stall -> re high cycles 1..785 with ctr1 0..784; re low cycles 786-787; re high 788..820 with ctr2 0..32; done = 1 at cycle 821 alongside wvalid = 1, w_layer = 1, w_idx = 32, w_last = 1; busy high cycles 1..821.
2. stall high for 5 cycles while ctr1 = 100 -> ctr1 holds at 100, re = 0, wvalid low for those 5 cycles; done moves to cycle 826.
3. stall high when ctr2 = 32 -> FSM stays in L2 and done waits; after stall drops, w_last rises on the following cycle together with done.
4. start pulsed again at cycle 300 and in the DONE cycle -> ignored; exactly one done pulse; ctr1 sequence unaffected.
5. reset asserted at cycle 400 (L1, ctr1 = 399) -> cycle 401: busy = 0, re = 0, ctr1 = 0, wvalid = 0; a new start then runs the full sequence from ctr1 = 0.
6. GAP = 0, L1_LEN = 4, L2_LEN = 2, WB_SEQ_PERF_EN defined, 1 stall cycle in L2 -> L2 entered directly after ctr1 = 3; run_cycles = 8; stall_cycles = 1.

Source files
------------

// File: rtl/wb_seq_ctrl_if.sv
// Bus bundle between wb_seq_ctrl and its neighbours (wbmem, MAC array, CPU glue).
// master = the sequencer, slave = the consumers that drive start/stall.
interface wb_seq_ctrl_if;
  logic        start;
  logic        stall;
  logic [31:0] ctr1;
  logic [31:0] ctr2;
  logic        re;
  logic        wvalid;
  logic        w_layer;
  logic [31:0] w_idx;
  logic        w_last;
  logic        busy;
  logic        done;

  modport master (
    input  start, stall,
    output ctr1, ctr2, re, wvalid, w_layer, w_idx, w_last, busy, done
  );

  modport slave (
    output start, stall,
    input  ctr1, ctr2, re, wvalid, w_layer, w_idx, w_last, busy, done
  );
endinterface

// File: rtl/wb_seq_ctrl.sv
// Weight/bias memory sequencer: sweeps layer-1 then layer-2 wbmem addresses with aligned tags.
// Optional WB_SEQ_PERF_EN adds run_cycles/stall_cycles performance counters.
module wb_seq_ctrl #(
  parameter int L1_LEN = 785,
  parameter int L2_LEN = 33,
  parameter int GAP    = 2
) (
  input  logic           clk,
  input  logic           reset,
  wb_seq_ctrl_if.master  bus
`ifdef WB_SEQ_PERF_EN
  ,
  output logic [31:0]    run_cycles,
  output logic [31:0]    stall_cycles
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_L1   = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_L2   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [9:0] L1_LAST  = 10'(L1_LEN - 1);
  localparam logic [9:0] L2_LAST  = 10'(L2_LEN - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
  localparam bit         GAP_SKIP = (GAP == 0);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [9:0] ctr1_r;
  logic [9:0] ctr2_r;
  logic [3:0] gap_cnt_r;
  logic [9:0] addr_s;
  logic       addr_last_s;
  logic       in_l1_s;
  logic       in_l2_s;
  logic       re_s;
  logic       l1_end_s;
  logic       l2_end_s;
  logic       wvalid_r;
  logic       w_layer_r;
  logic       w_last_r;
  logic [9:0] w_idx_r;

  // Issue decode: read enable, final-word detection and the active layer's address.
  always_comb begin
    in_l1_s  = (state_r == S_L1);
    in_l2_s  = (state_r == S_L2);
    re_s     = (in_l1_s || in_l2_s) && !bus.stall;
    l1_end_s = in_l1_s && re_s && (ctr1_r == L1_LAST);
    l2_end_s = in_l2_s && re_s && (ctr2_r == L2_LAST);
    if (in_l2_s) begin
      addr_s      = ctr2_r;
      addr_last_s = (ctr2_r == L2_LAST);
    end else begin
      addr_s      = ctr1_r;
      addr_last_s = (ctr1_r == L1_LAST);
    end
  end

  // Next-state logic; transitions out of L1/L2 only happen on an actual issue of the last word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_nxt_s = S_L1;
        else           state_nxt_s = S_IDLE;
      end
      S_L1: begin
        if (l1_end_s) state_nxt_s = GAP_SKIP ? S_L2 : S_GAP1;
        else          state_nxt_s = S_L1;
      end
      S_GAP1: begin
        if (gap_cnt_r == 4'd0) state_nxt_s = S_L2;
        else                   state_nxt_s = S_GAP1;
      end
      S_L2: begin
        if (l2_end_s) state_nxt_s = S_DONE;
        else          state_nxt_s = S_L2;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, address counters, gap timer and one-cycle-delayed read tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      ctr1_r    <= 10'd0;
      ctr2_r    <= 10'd0;
      gap_cnt_r <= 4'd0;
      wvalid_r  <= 1'b0;
      w_layer_r <= 1'b0;
      w_last_r  <= 1'b0;
      w_idx_r   <= 10'd0;
    end else begin
      state_r <= state_nxt_s;
      if (in_l1_s && re_s) ctr1_r <= l1_end_s ? 10'd0 : ctr1_r + 10'd1;
      else                 ctr1_r <= ctr1_r;
      if (in_l2_s && re_s) ctr2_r <= l2_end_s ? 10'd0 : ctr2_r + 10'd1;
      else                 ctr2_r <= ctr2_r;
      if (l1_end_s)                                      gap_cnt_r <= GAP_LOAD;
      else if (state_r == S_GAP1 && gap_cnt_r != 4'd0)   gap_cnt_r <= gap_cnt_r - 4'd1;
      else                                               gap_cnt_r <= gap_cnt_r;
      wvalid_r  <= re_s;
      w_idx_r   <= addr_s;
      w_layer_r <= in_l2_s;
      w_last_r  <= re_s && addr_last_s;
    end
  end

  assign bus.ctr1    = {22'd0, ctr1_r};
  assign bus.ctr2    = {22'd0, ctr2_r};
  assign bus.re      = re_s;
  assign bus.wvalid  = wvalid_r;
  assign bus.w_layer = w_layer_r;
  assign bus.w_idx   = {22'd0, w_idx_r};
  assign bus.w_last  = w_last_r;
  assign bus.busy    = (state_r != S_IDLE);
  assign bus.done    = (state_r == S_DONE);

`ifdef WB_SEQ_PERF_EN
  logic [31:0] run_cycles_r;
  logic [31:0] stall_cycles_r;

  // Saturating busy/stall cycle counters, cleared when a start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_r   <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else if (state_r == S_IDLE && bus.start) begin
      run_cycles_r   <= 32'd0;
      stall_cycles_r <= 32'd0;
    end else begin
      if (state_r != S_IDLE && run_cycles_r != 32'hFFFF_FFFF)
        run_cycles_r <= run_cycles_r + 32'd1;
      else
        run_cycles_r <= run_cycles_r;
      if ((in_l1_s || in_l2_s) && bus.stall && stall_cycles_r != 32'hFFFF_FFFF)
        stall_cycles_r <= stall_cycles_r + 32'd1;
      else
        stall_cycles_r <= stall_cycles_r;
    end
  end

  assign run_cycles   = run_cycles_r;
  assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Self-checking bench for wb_seq_ctrl: a default-parameter instance and a short GAP=0 instance,
// both checked cycle by cycle against a word-tape reference model.
module tb_wb_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_seq_ctrl_if bd();
  wb_seq_ctrl_if bs();

`ifdef WB_SEQ_PERF_EN
  logic [31:0] d_run, d_stall, s_run, s_stall;
`endif

  wb_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bd)
`ifdef WB_SEQ_PERF_EN
    ,
    .run_cycles   (d_run),
    .stall_cycles (d_stall)
`endif
  );

  wb_seq_ctrl #(.L1_LEN(4), .L2_LEN(2), .GAP(0)) dut_s (
    .clk          (clk),
    .reset        (reset),
    .bus          (bs)
`ifdef WB_SEQ_PERF_EN
    ,
    .run_cycles   (s_run),
    .stall_cycles (s_stall)
`endif
  );

  typedef struct {
    logic [31:0] ctr1, ctr2, w_idx;
    logic        re, wvalid, w_layer, w_last, busy, done;
  } obs_t;

  function automatic obs_t sample(input bit s);
    obs_t o;
    if (s) begin
      o.ctr1 = bs.ctr1; o.ctr2 = bs.ctr2; o.w_idx = bs.w_idx; o.re = bs.re;
      o.wvalid = bs.wvalid; o.w_layer = bs.w_layer; o.w_last = bs.w_last;
      o.busy = bs.busy; o.done = bs.done;
    end else begin
      o.ctr1 = bd.ctr1; o.ctr2 = bd.ctr2; o.w_idx = bd.w_idx; o.re = bd.re;
      o.wvalid = bd.wvalid; o.w_layer = bd.w_layer; o.w_last = bd.w_last;
      o.busy = bd.busy; o.done = bd.done;
    end
    return o;
  endfunction

  task automatic drive(input bit s, input logic st, input logic sl);
    if (s) begin bs.start = st; bs.stall = sl; end
    else   begin bd.start = st; bd.stall = sl; end
  endtask

  // Model: the run is a tape of l1 words, gap idle slots, l2 words and one DONE slot.
  // mode: 0 none, 1 stall 5 at ctr1=100, 2 stall 3 on last L2 word, 3 random stall,
  //       4 extra starts at cycle 300 and in DONE, 5 one stall on first L2 word.
  task automatic run_seq(input string name, input bit s, input int l1, input int l2,
                         input int gap, input int mode, input int abort_at,
                         output int done_cyc, output int n_done);
    int   p, total, stall_left, model_done, cur_idx, prev_idx, e_c1, e_c2;
    bit   active, prev_re, prev_l2, prev_last, cur_l2, cur_last, e_re, e_done;
    logic st, sl;
    obs_t o;
    total = l1 + gap + l2;
    p = 0; active = 1'b0; prev_re = 1'b0; prev_idx = 0; prev_l2 = 1'b0; prev_last = 1'b0;
    stall_left = (mode == 1) ? 5 : ((mode == 2) ? 3 : ((mode == 5) ? 1 : 0));
    model_done = -1; done_cyc = -1; n_done = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      st = (c == 0);
      sl = 1'b0;
      if (mode == 4 && (c == 300 || (active && p == total))) st = 1'b1;
      if (active && stall_left > 0 &&
          ((mode == 1 && p == 100) || (mode == 2 && p == total - 1) ||
           (mode == 5 && p == l1 + gap))) begin
        sl = 1'b1; stall_left--;
      end
      if (mode == 3) sl = ($urandom_range(0, 2) == 0);
      reset = (c == abort_at);
      drive(s, st, sl);

      e_re = 1'b0; e_done = 1'b0; e_c1 = 0; e_c2 = 0;
      cur_idx = 0; cur_l2 = 1'b0; cur_last = 1'b0;
      if (active) begin
        if (p < l1) begin
          e_c1 = p; e_re = !sl; cur_idx = p; cur_last = (p == l1 - 1);
        end else if (p < l1 + gap) begin
          e_re = 1'b0;
        end else if (p < total) begin
          e_c2 = p - l1 - gap; e_re = !sl; cur_idx = e_c2; cur_l2 = 1'b1;
          cur_last = (e_c2 == l2 - 1);
        end else begin
          e_done = 1'b1;
        end
      end

      @(negedge clk);
      o = sample(s);
      checks++;
      if (o.re !== e_re) begin errors++;
        $display("FAIL %s re @%0d: got %b exp %b", name, c, o.re, e_re); end
      checks++;
      if (o.busy !== active) begin errors++;
        $display("FAIL %s busy @%0d: got %b exp %b", name, c, o.busy, active); end
      checks++;
      if (o.done !== e_done) begin errors++;
        $display("FAIL %s done @%0d: got %b exp %b", name, c, o.done, e_done); end
      checks++;
      if (o.ctr1 !== 32'(e_c1)) begin errors++;
        $display("FAIL %s ctr1 @%0d: got %0d exp %0d", name, c, o.ctr1, e_c1); end
      checks++;
      if (o.ctr2 !== 32'(e_c2)) begin errors++;
        $display("FAIL %s ctr2 @%0d: got %0d exp %0d", name, c, o.ctr2, e_c2); end
      checks++;
      if (o.wvalid !== prev_re) begin errors++;
        $display("FAIL %s wvalid @%0d: got %b exp %b", name, c, o.wvalid, prev_re); end
      checks++;
      if (o.w_last !== prev_last) begin errors++;
        $display("FAIL %s w_last @%0d: got %b exp %b", name, c, o.w_last, prev_last); end
      if (prev_re) begin
        checks++;
        if (o.w_idx !== 32'(prev_idx)) begin errors++;
          $display("FAIL %s w_idx @%0d: got %0d exp %0d", name, c, o.w_idx, prev_idx); end
        checks++;
        if (o.w_layer !== prev_l2) begin errors++;
          $display("FAIL %s w_layer @%0d: got %b exp %b", name, c, o.w_layer, prev_l2); end
      end
      if (o.done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end

      prev_re = e_re; prev_idx = cur_idx; prev_l2 = cur_l2; prev_last = e_re && cur_last;
      if (!active) begin
        if (st) begin active = 1'b1; p = 0; end
      end else if (e_done) begin
        active = 1'b0; model_done = c;
      end else if (p >= l1 && p < l1 + gap) begin
        p++;
      end else if (e_re) begin
        p++;
      end
      if (c == abort_at) begin active = 1'b0; prev_re = 1'b0; prev_last = 1'b0; end
      if (abort_at >= 0 && c == abort_at + 1) break;
      if (model_done >= 0 && c >= model_done + 4) break;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(s, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      checks++;
      if ({o.re, o.wvalid, o.w_layer, o.w_last, o.busy, o.done} !== 6'b0 ||
          o.ctr1 !== 32'd0 || o.ctr2 !== 32'd0 || o.w_idx !== 32'd0) begin
        errors++;
        $display("FAIL reset_state inst %0d: ctr1 %0d ctr2 %0d idx %0d flags %b exp all 0",
                 s, o.ctr1, o.ctr2, o.w_idx, {o.re, o.wvalid, o.w_layer, o.w_last, o.busy, o.done});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic expect_done(input string name, input int got_cyc, input int exp_cyc, input int got_n);
    checks++;
    if (got_cyc !== exp_cyc) begin errors++;
      $display("FAIL %s done_cycle: got %0d exp %0d", name, got_cyc, exp_cyc); end
    checks++;
    if (got_n !== 1) begin errors++;
      $display("FAIL %s done_pulses: got %0d exp 1", name, got_n); end
  endtask

  task automatic test_nominal();
    int dc, nd;
    run_seq("nominal", 1'b0, 785, 33, 2, 0, -1, dc, nd);
    expect_done("nominal", dc, 821, nd);
  endtask

  task automatic test_stall_l1();
    int dc, nd;
    run_seq("stall_l1", 1'b0, 785, 33, 2, 1, -1, dc, nd);
    expect_done("stall_l1", dc, 826, nd);
  endtask

  task automatic test_stall_last();
    int dc, nd;
    run_seq("stall_last", 1'b0, 785, 33, 2, 2, -1, dc, nd);
    expect_done("stall_last", dc, 824, nd);
  endtask

  task automatic test_start_ignored();
    int dc, nd;
    run_seq("start_ign", 1'b0, 785, 33, 2, 4, -1, dc, nd);
    expect_done("start_ign", dc, 821, nd);
  endtask

  task automatic test_reset_mid();
    int dc, nd;
    run_seq("reset_mid", 1'b0, 785, 33, 2, 0, 400, dc, nd);
    checks++;
    if (nd !== 0) begin errors++;
      $display("FAIL reset_mid done_pulses: got %0d exp 0", nd); end
    run_seq("after_reset", 1'b0, 785, 33, 2, 0, -1, dc, nd);
    expect_done("after_reset", dc, 821, nd);
  endtask

  task automatic test_random();
    int dc, nd;
    run_seq("random_big", 1'b0, 785, 33, 2, 3, -1, dc, nd);
    checks++;
    if (nd !== 1) begin errors++;
      $display("FAIL random_big done_pulses: got %0d exp 1", nd); end
    for (int k = 0; k < 6; k++) begin
      run_seq("random_small", 1'b1, 4, 2, 0, 3, -1, dc, nd);
      checks++;
      if (nd !== 1) begin errors++;
        $display("FAIL random_small done_pulses: got %0d exp 1", nd); end
    end
  endtask

  task automatic test_gap0_short();
    int dc, nd;
    run_seq("gap0", 1'b1, 4, 2, 0, 5, -1, dc, nd);
    expect_done("gap0", dc, 8, nd);
`ifdef WB_SEQ_PERF_EN
    checks++;
    if (s_run !== 32'd8) begin errors++;
      $display("FAIL gap0 run_cycles: got %0d exp 8", s_run); end
    checks++;
    if (s_stall !== 32'd1) begin errors++;
      $display("FAIL gap0 stall_cycles: got %0d exp 1", s_stall); end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall_l1();
    test_stall_last();
    test_start_ignored();
    test_reset_mid();
    test_gap0_short();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
